// File: rtl/pb_event_pkg.sv
// Shared definitions for the push-button event debouncer: parameter defaults,
// the per-channel debounced state type and a width helper.
package pb_event_pkg;

  localparam int PB_TICK_DIV_DEF   = 1000;
  localparam int PB_DEB_TICKS_DEF  = 500;
  localparam int PB_LONG_TICKS_DEF = 100000;

  typedef enum logic {PB_REL = 1'b0, PB_PRS = 1'b1} pb_state_e;

  // Counter width that never collapses to zero bits for tiny parameter values.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pb_tick_gen.sv
// Free-running sample-tick generator shared by every debounce channel.
// tick is high for one clk when the count sits at TICK_DIV-1.
module pb_tick_gen
  import pb_event_pkg::*;
#(
  parameter int TICK_DIV = PB_TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = clog2_min1(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/pb_event_debounce.sv
// Multi-channel push-button debouncer with press/release/long-press pulses,
// sticky press status and a maskable registered interrupt.
//
//   state  | meaning
//   PB_REL | debounced level is released
//   PB_PRS | debounced level is pressed
module pb_event_debounce
  import pb_event_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int TICK_DIV   = PB_TICK_DIV_DEF,
  parameter int DEB_TICKS  = PB_DEB_TICKS_DEF,
  parameter int LONG_TICKS = PB_LONG_TICKS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] pb_in,
  output logic [NUM_CH-1:0] pb_level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] long_pulse,
  output logic [NUM_CH-1:0] evt_status,
  input  logic [NUM_CH-1:0] evt_clr,
  input  logic [NUM_CH-1:0] irq_mask,
  output logic              irq
);

  localparam int DCW = clog2_min1(DEB_TICKS + 1);
  localparam int HCW = clog2_min1(LONG_TICKS + 1);

  localparam logic             INACT     = (ACTIVE_LOW != 0);
  localparam logic [DCW-1:0]   DEB_LAST  = DCW'(DEB_TICKS - 1);
  localparam logic [HCW-1:0]   HOLD_MAX  = HCW'(LONG_TICKS);
  localparam logic [HCW-1:0]   HOLD_LAST = HCW'(LONG_TICKS - 1);

  logic tick;

  pb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic           sync_q1, sync_q2, s;
    pb_state_e      stable;
    logic [DCW-1:0] dcnt;
    logic [HCW-1:0] hcnt;
    logic           prs_q, rel_q, long_q;

    // Normalised so that 1 always means pressed.
    assign s = sync_q2 ^ INACT;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q1 <= INACT;
        sync_q2 <= INACT;
        stable  <= PB_REL;
        dcnt    <= '0;
        hcnt    <= '0;
        prs_q   <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        sync_q1 <= pb_in[i];
        sync_q2 <= sync_q1;
        prs_q   <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;

        if (s == stable) begin
          dcnt <= '0;
        end else if (tick) begin
          if (dcnt == DEB_LAST) begin
            stable <= pb_state_e'(s);
            dcnt   <= '0;
            prs_q  <= s;
            rel_q  <= ~s;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end

        // Saturating hold count: long_q fires only on the step into HOLD_MAX.
        if (stable == PB_REL) begin
          hcnt <= '0;
        end else if (tick && (hcnt != HOLD_MAX)) begin
          hcnt   <= hcnt + HCW'(1);
          long_q <= (hcnt == HOLD_LAST);
        end
      end
    end

    assign pb_level[i]      = (stable == PB_PRS);
    assign press_pulse[i]   = prs_q;
    assign release_pulse[i] = rel_q;
    assign long_pulse[i]    = long_q;
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_status <= '0;
      irq        <= 1'b0;
    end else begin
      evt_status <= (evt_status & ~evt_clr) | press_pulse;
      irq        <= |(evt_status & irq_mask);
    end
  end

endmodule
